// File: rtl/video_timing_detector.sv
// video_timing_detector: recovers raster coordinates and line/frame geometry
// from a pixel-clocked hsync/vsync/de stream, and locks onto stable timing.
//
// Ports:
//   i_clk_pxl   pixel clock
//   i_reset     synchronous, active-high reset
//   i_hsync     horizontal sync, active-high pulse
//   i_vsync     vertical sync, active-high pulse
//   i_de        data enable, high on active pixels
//   o_sx/o_sy   coordinates of the pixel now on o_de (0,0 = first active)
//   o_de        i_de delayed by one clock
//   o_nf        new-frame pulse on pixel (0,0) while locked
//   o_h_total   measured clocks per line (last lock)
//   o_h_active  measured active clocks per line (last lock)
//   o_v_total   measured lines per frame (last lock)
//   o_v_active  measured active lines per frame (last lock)
//   o_locked    stable timing detected
//   o_err       one-cycle pulse when lock is lost
module video_timing_detector #(
    parameter int MAX_H_TOTAL = 2047,
    parameter int MAX_V_TOTAL = 1023,
    parameter int LOCK_FRAMES = 2,
    localparam int H_W = $clog2(MAX_H_TOTAL + 1),
    localparam int V_W = $clog2(MAX_V_TOTAL + 1)
) (
    input  logic           i_clk_pxl,
    input  logic           i_reset,
    input  logic           i_hsync,
    input  logic           i_vsync,
    input  logic           i_de,
    output logic [H_W-1:0] o_sx,
    output logic [V_W-1:0] o_sy,
    output logic           o_de,
    output logic           o_nf,
    output logic [H_W-1:0] o_h_total,
    output logic [H_W-1:0] o_h_active,
    output logic [V_W-1:0] o_v_total,
    output logic [V_W-1:0] o_v_active,
    output logic           o_locked,
    output logic           o_err
);

    typedef enum logic [1:0] {
        SEARCH  = 2'd0,
        MEASURE = 2'd1,
        LOCKED  = 2'd2
    } state_t;

    typedef struct packed {
        logic [H_W-1:0] h_total;
        logic [H_W-1:0] h_active;
        logic [V_W-1:0] v_total;
        logic [V_W-1:0] v_active;
    } geom_t;

    localparam logic [H_W-1:0] H_SAT  = H_W'(MAX_H_TOTAL);
    localparam logic [H_W-1:0] H_ONES = '1;
    localparam logic [V_W-1:0] V_ONES = '1;
    localparam logic [3:0]     LOCK_LAST = 4'(LOCK_FRAMES - 1);

    // previous input samples for edge detection
    logic hs_p;
    logic vs_p;
    logic de_p;

    logic hs_rise;
    logic vs_rise;
    logic de_rise;
    logic de_fall;

    assign hs_rise = i_hsync & ~hs_p;
    assign vs_rise = i_vsync & ~vs_p;
    assign de_rise = i_de & ~de_p;
    assign de_fall = ~i_de & de_p;

    // per-line and per-frame counters
    logic [H_W-1:0] h_cnt;
    logic [H_W-1:0] a_cnt;
    logic [H_W-1:0] line_h_total;
    logic [H_W-1:0] line_h_active;
    logic [V_W-1:0] l_cnt;
    logic [V_W-1:0] la_cnt;
    logic           first_line_pending;
    logic           h_sat;

    // a line that never ends (no hsync) pins h_cnt at its ceiling
    assign h_sat = !hs_rise && (h_cnt == H_SAT);

    // candidate geometry for the frame ending on this vs_rise; an
    // hsync/de edge coinciding with vsync still belongs to the old frame
    geom_t cand;

    always_comb begin
        cand.h_total  = hs_rise ? h_cnt : line_h_total;
        cand.h_active = de_fall ? a_cnt : line_h_active;
        cand.v_total  = (hs_rise && l_cnt != V_ONES) ? l_cnt + 1'b1 : l_cnt;
        cand.v_active = la_cnt;
    end

    always_ff @(posedge i_clk_pxl) begin
        if (i_reset) begin
            hs_p               <= 1'b0;
            vs_p               <= 1'b0;
            de_p               <= 1'b0;
            h_cnt              <= '0;
            a_cnt              <= '0;
            line_h_total       <= '0;
            line_h_active      <= '0;
            l_cnt              <= '0;
            la_cnt             <= '0;
            first_line_pending <= 1'b0;
            o_sx               <= '0;
            o_sy               <= '0;
            o_de               <= 1'b0;
            o_nf               <= 1'b0;
        end else begin
            hs_p <= i_hsync;
            vs_p <= i_vsync;
            de_p <= i_de;

            if (hs_rise) begin
                line_h_total <= h_cnt;
                h_cnt        <= H_W'(1);
            end else if (h_cnt != H_SAT) begin
                h_cnt <= h_cnt + 1'b1;
            end

            if (de_rise) begin
                a_cnt <= H_W'(1);
            end else if (i_de && a_cnt != H_ONES) begin
                a_cnt <= a_cnt + 1'b1;
            end

            if (de_fall) begin
                line_h_active <= a_cnt;
            end

            if (vs_rise) begin
                l_cnt  <= '0;
                la_cnt <= {{(V_W-1){1'b0}}, de_rise};
            end else begin
                if (hs_rise && l_cnt != V_ONES) begin
                    l_cnt <= l_cnt + 1'b1;
                end
                if (de_rise && la_cnt != V_ONES) begin
                    la_cnt <= la_cnt + 1'b1;
                end
            end

            o_de <= i_de;

            if (de_rise) begin
                o_sx <= '0;
            end else if (i_de && o_sx != H_ONES) begin
                o_sx <= o_sx + 1'b1;
            end

            if (de_rise) begin
                if (first_line_pending || vs_rise) begin
                    o_sy <= '0;
                end else if (o_sy != V_ONES) begin
                    o_sy <= o_sy + 1'b1;
                end
            end

            if (de_rise) begin
                first_line_pending <= 1'b0;
            end else if (vs_rise) begin
                first_line_pending <= 1'b1;
            end

            o_nf <= o_locked && de_rise && (first_line_pending || vs_rise);
        end
    end

    // lock state machine
    state_t state_q;
    state_t state_d;
    logic [3:0] match_q;
    logic [3:0] match_d;
    geom_t ref_q;
    geom_t ref_d;
    logic  ref_vld_q;
    logic  ref_vld_d;
    geom_t meas_q;
    geom_t meas_d;
    logic  locked_d;
    logic  err_d;
    logic  cand_eq;

    // an invalid reference never matches, so a fresh search always
    // needs one full frame to seed it before counting matches
    assign cand_eq = ref_vld_q && (cand == ref_q);

    always_comb begin
        state_d   = state_q;
        match_d   = match_q;
        ref_d     = ref_q;
        ref_vld_d = ref_vld_q;
        meas_d    = meas_q;
        locked_d  = o_locked;
        err_d     = 1'b0;
        if (h_sat) begin
            state_d   = SEARCH;
            match_d   = '0;
            ref_vld_d = 1'b0;
            locked_d  = 1'b0;
            err_d     = (state_q == LOCKED);
        end else begin
            unique case (state_q)
                SEARCH: begin
                    if (vs_rise) begin
                        state_d = MEASURE;
                        match_d = '0;
                    end
                end
                MEASURE: begin
                    if (vs_rise) begin
                        if (LOCK_FRAMES == 1) begin
                            ref_d     = cand;
                            ref_vld_d = 1'b1;
                            meas_d    = cand;
                            locked_d  = 1'b1;
                            match_d   = '0;
                            state_d   = LOCKED;
                        end else if (cand_eq) begin
                            if (match_q + 4'd1 == LOCK_LAST) begin
                                meas_d   = ref_q;
                                locked_d = 1'b1;
                                match_d  = '0;
                                state_d  = LOCKED;
                            end else begin
                                match_d = match_q + 4'd1;
                            end
                        end else begin
                            ref_d     = cand;
                            ref_vld_d = 1'b1;
                            match_d   = '0;
                        end
                    end
                end
                LOCKED: begin
                    if (hs_rise && h_cnt != meas_q.h_total) begin
                        err_d     = 1'b1;
                        locked_d  = 1'b0;
                        ref_vld_d = 1'b0;
                        match_d   = '0;
                        state_d   = SEARCH;
                    end else if (vs_rise && !cand_eq) begin
                        err_d     = 1'b1;
                        locked_d  = 1'b0;
                        ref_d     = cand;
                        ref_vld_d = 1'b1;
                        match_d   = '0;
                        state_d   = MEASURE;
                    end
                end
                default: begin
                    state_d  = SEARCH;
                    locked_d = 1'b0;
                end
            endcase
        end
    end

    always_ff @(posedge i_clk_pxl) begin
        if (i_reset) begin
            state_q   <= SEARCH;
            match_q   <= '0;
            ref_q     <= '0;
            ref_vld_q <= 1'b0;
            meas_q    <= '0;
            o_locked  <= 1'b0;
            o_err     <= 1'b0;
        end else begin
            state_q   <= state_d;
            match_q   <= match_d;
            ref_q     <= ref_d;
            ref_vld_q <= ref_vld_d;
            meas_q    <= meas_d;
            o_locked  <= locked_d;
            o_err     <= err_d;
        end
    end

    assign o_h_total  = meas_q.h_total;
    assign o_h_active = meas_q.h_active;
    assign o_v_total  = meas_q.v_total;
    assign o_v_active = meas_q.v_active;

endmodule

// File: tb/tb_video_timing_detector.sv
// tb_video_timing_detector: directed bench for video_timing_detector
// using a small raster (40 clk/line, 32 active, 12 lines, 8 active).
module tb_video_timing_detector;

    logic        clk;
    logic        i_reset;
    logic        i_hsync;
    logic        i_vsync;
    logic        i_de;
    logic [10:0] o_sx;
    logic [9:0]  o_sy;
    logic        o_de;
    logic        o_nf;
    logic [10:0] o_h_total;
    logic [10:0] o_h_active;
    logic [9:0]  o_v_total;
    logic [9:0]  o_v_active;
    logic        o_locked;
    logic        o_err;

    int checks = 0;
    int errors = 0;
    int err_pulses;

    video_timing_detector dut (
        .i_clk_pxl (clk),
        .i_reset   (i_reset),
        .i_hsync   (i_hsync),
        .i_vsync   (i_vsync),
        .i_de      (i_de),
        .o_sx      (o_sx),
        .o_sy      (o_sy),
        .o_de      (o_de),
        .o_nf      (o_nf),
        .o_h_total (o_h_total),
        .o_h_active(o_h_active),
        .o_v_total (o_v_total),
        .o_v_active(o_v_active),
        .o_locked  (o_locked),
        .o_err     (o_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // one pixel clock of the raster; outputs are sampled 1 ns after the edge
    task automatic px(input int h, input int v);
        i_hsync = (h >= 34 && h < 38);
        i_vsync = (v == 9 || v == 10);
        i_de    = (h < 32 && v < 8);
        @(posedge clk);
        #1;
    endtask

    task automatic pixels(input int v, input int h0, input int h1);
        for (int h = h0; h <= h1; h++) px(h, v);
    endtask

    task automatic lines(input int v0, input int v1);
        for (int v = v0; v <= v1; v++) pixels(v, 0, 39);
    endtask

    initial begin
        i_reset = 1'b1;
        i_hsync = 1'b0;
        i_vsync = 1'b0;
        i_de    = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_locked", o_locked, 0);
        chk("rst_de", o_de, 0);
        chk("rst_sx", o_sx, 0);
        chk("rst_h_total", o_h_total, 0);
        chk("rst_err", o_err, 0);
        i_reset = 1'b0;

        // frames 0..2: lock on the third vs_rise
        lines(0, 11);
        lines(0, 11);
        lines(0, 8);
        chk("lock_before3", o_locked, 0);
        px(0, 9);
        chk("lock_at3", o_locked, 1);
        chk("h_total", o_h_total, 40);
        chk("h_active", o_h_active, 32);
        chk("v_total", o_v_total, 12);
        chk("v_active", o_v_active, 8);
        pixels(9, 1, 39);
        lines(10, 11);

        // frame 3: first and last active pixel
        px(0, 0);
        chk("nf_first", o_nf, 1);
        chk("de_first", o_de, 1);
        chk("sx_first", o_sx, 0);
        chk("sy_first", o_sy, 0);
        px(1, 0);
        chk("nf_once", o_nf, 0);
        chk("sx_second", o_sx, 1);
        pixels(0, 2, 39);
        lines(1, 6);
        pixels(7, 0, 31);
        chk("sx_last", o_sx, 31);
        chk("sy_last", o_sy, 7);
        chk("de_last", o_de, 1);
        pixels(7, 32, 39);
        chk("de_blank", o_de, 0);
        lines(8, 11);

        // frame 4: line 3 is one clock short
        lines(0, 2);
        pixels(3, 0, 38);
        pixels(4, 0, 33);
        chk("short_pre_err", o_err, 0);
        chk("short_pre_lock", o_locked, 1);
        px(34, 4);
        chk("short_err", o_err, 1);
        chk("short_unlock", o_locked, 0);
        px(35, 4);
        chk("short_err_pulse", o_err, 0);
        pixels(4, 36, 39);
        lines(5, 11);
        lines(0, 11);
        lines(0, 8);
        chk("short_nolock2", o_locked, 0);
        px(0, 9);
        chk("short_relock3", o_locked, 1);
        pixels(9, 1, 39);
        lines(10, 11);

        // frames 7..9: 11-line frames
        lines(0, 10);
        lines(0, 8);
        chk("vchg_pre_lock", o_locked, 1);
        chk("vchg_pre_err", o_err, 0);
        px(0, 9);
        chk("vchg_err", o_err, 1);
        chk("vchg_unlock", o_locked, 0);
        px(1, 9);
        chk("vchg_err_pulse", o_err, 0);
        pixels(9, 2, 39);
        lines(10, 10);
        lines(0, 8);
        chk("vchg_nolock", o_locked, 0);
        px(0, 9);
        chk("vchg_relock", o_locked, 1);
        chk("vchg_v_total", o_v_total, 11);
        chk("vchg_h_total", o_h_total, 40);
        pixels(9, 1, 39);
        pixels(10, 0, 39);

        // hsync stops: h_cnt saturates and lock is lost once
        i_hsync = 1'b0;
        i_vsync = 1'b0;
        i_de    = 1'b0;
        repeat (2000) begin
            @(posedge clk);
            #1;
        end
        chk("sat_still_locked", o_locked, 1);
        err_pulses = 0;
        repeat (100) begin
            @(posedge clk);
            #1;
            if (o_err) err_pulses++;
        end
        chk("sat_err_pulses", err_pulses, 1);
        chk("sat_unlock", o_locked, 0);
        chk("sat_hold_v_total", o_v_total, 11);

        // relock on 12-line frames
        lines(0, 11);
        lines(0, 11);
        lines(0, 8);
        chk("sat_nolock2", o_locked, 0);
        px(0, 9);
        chk("sat_relock", o_locked, 1);
        chk("sat_relock_vt", o_v_total, 12);
        pixels(9, 1, 39);
        lines(10, 11);

        // reset mid-line while locked
        lines(0, 1);
        pixels(2, 0, 15);
        chk("mid_pre_de", o_de, 1);
        i_reset = 1'b1;
        px(16, 2);
        chk("mrst_locked", o_locked, 0);
        chk("mrst_de", o_de, 0);
        chk("mrst_sx", o_sx, 0);
        chk("mrst_sy", o_sy, 0);
        chk("mrst_nf", o_nf, 0);
        chk("mrst_err", o_err, 0);
        chk("mrst_h_total", o_h_total, 0);
        chk("mrst_h_active", o_h_active, 0);
        chk("mrst_v_total", o_v_total, 0);
        chk("mrst_v_active", o_v_active, 0);
        i_reset = 1'b0;
        pixels(2, 17, 39);
        lines(3, 11);
        lines(0, 11);
        lines(0, 8);
        chk("mrst_nolock2", o_locked, 0);
        px(0, 9);
        chk("mrst_relock3", o_locked, 1);
        chk("mrst_h_total2", o_h_total, 40);
        chk("mrst_v_active2", o_v_active, 8);
        pixels(9, 1, 39);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
